alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 96 +++++++++
 tb/tb_alu_exec_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the 5-stage MIPS pipeline: decodes the ALU control, picks
// operand B, computes result/zero/branch target, and registers them into EX/MEM.
module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  in_alu_op,
  input  logic        in_alu_src,
  input  logic [31:0] in_reg_data1,
  input  logic [31:0] in_reg_data2,
  input  logic [31:0] in_sign_ext,
  input  logic [31:0] in_inc_pc,
  output logic [2:0]  out_alu_ctrl,
  output logic [31:0] out_alu_result,
  output logic        out_zero,
  output logic [31:0] out_branch_address
);

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_NOR = 3'b100;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  logic [2:0]  alu_ctrl_d,  alu_ctrl_q;
  logic [31:0] alu_result_d, alu_result_q;
  logic        zero_d,      zero_q;
  logic [31:0] branch_d,    branch_q;
  logic [31:0] operand_b_s;
  logic [5:0]  funct_s;

  assign funct_s = in_sign_ext[5:0];

  // ALU control decode from main-control opcode and funct field
  always_comb begin
    alu_ctrl_d = CTRL_ADD;
    case (in_alu_op)
      2'b00: alu_ctrl_d = CTRL_ADD;
      2'b01: alu_ctrl_d = CTRL_SUB;
      2'b10: begin
        case (funct_s)
          6'b100000: alu_ctrl_d = CTRL_ADD;
          6'b100010: alu_ctrl_d = CTRL_SUB;
          6'b100100: alu_ctrl_d = CTRL_AND;
          6'b100101: alu_ctrl_d = CTRL_OR;
          6'b101010: alu_ctrl_d = CTRL_SLT;
          6'b100111: alu_ctrl_d = CTRL_NOR;
          default:   alu_ctrl_d = CTRL_ADD;
        endcase
      end
      2'b11:   alu_ctrl_d = CTRL_OR;
      default: alu_ctrl_d = CTRL_ADD;
    endcase
  end

  assign operand_b_s = in_alu_src ? in_sign_ext : in_reg_data2;

  // ALU datapath; add/sub wrap silently, unused codes yield zero
  always_comb begin
    alu_result_d = 32'd0;
    case (alu_ctrl_d)
      CTRL_AND: alu_result_d = in_reg_data1 & operand_b_s;
      CTRL_OR:  alu_result_d = in_reg_data1 | operand_b_s;
      CTRL_ADD: alu_result_d = in_reg_data1 + operand_b_s;
      CTRL_SUB: alu_result_d = in_reg_data1 - operand_b_s;
      CTRL_SLT: alu_result_d = ($signed(in_reg_data1) < $signed(operand_b_s)) ? 32'd1 : 32'd0;
      CTRL_NOR: alu_result_d = ~(in_reg_data1 | operand_b_s);
      default:  alu_result_d = 32'd0;
    endcase
  end

  assign zero_d = (alu_result_d == 32'd0);
  // Word offset: dropping the top two bits keeps negative offsets correct mod 2^32
  assign branch_d = in_inc_pc + {in_sign_ext[29:0], 2'b00};

  // EX/MEM boundary registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_ctrl_q   <= 3'b000;
      alu_result_q <= 32'd0;
      zero_q       <= 1'b0;
      branch_q     <= 32'd0;
    end else begin
      alu_ctrl_q   <= alu_ctrl_d;
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      branch_q     <= branch_d;
    end
  end

  assign out_alu_ctrl       = alu_ctrl_q;
  assign out_alu_result     = alu_result_q;
  assign out_zero           = zero_q;
  assign out_branch_address = branch_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  in_alu_op;
  logic        in_alu_src;
  logic [31:0] in_reg_data1;
  logic [31:0] in_reg_data2;
  logic [31:0] in_sign_ext;
  logic [31:0] in_inc_pc;
  logic [2:0]  out_alu_ctrl;
  logic [31:0] out_alu_result;
  logic        out_zero;
  logic [31:0] out_branch_address;

  int checks = 0;
  int errors = 0;

  alu_exec_unit dut (
    .clk                (clk),
    .reset              (reset),
    .in_alu_op          (in_alu_op),
    .in_alu_src         (in_alu_src),
    .in_reg_data1       (in_reg_data1),
    .in_reg_data2       (in_reg_data2),
    .in_sign_ext        (in_sign_ext),
    .in_inc_pc          (in_inc_pc),
    .out_alu_ctrl       (out_alu_ctrl),
    .out_alu_result     (out_alu_result),
    .out_zero           (out_zero),
    .out_branch_address (out_branch_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ctrl, input logic [31:0] res,
                         input logic zero, input logic [31:0] br);
    chk({tag, ".ctrl"},   {29'd0, out_alu_ctrl}, {29'd0, ctrl});
    chk({tag, ".result"}, out_alu_result, res);
    chk({tag, ".zero"},   {31'd0, out_zero}, {31'd0, zero});
    chk({tag, ".branch"}, out_branch_address, br);
  endtask

  task automatic drive(input logic [1:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] se, input logic [31:0] pc);
    in_alu_op    = op;
    in_alu_src   = src;
    in_reg_data1 = a;
    in_reg_data2 = b;
    in_sign_ext  = se;
    in_inc_pc    = pc;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with nonzero inputs: outputs clear at once and hold through an edge
    reset = 1'b0;
    drive(2'b00, 1'b0, 32'd5, 32'd3, 32'h20, 32'd40);
    #2;
    chk_all("reset_immediate", 3'b000, 32'd0, 1'b0, 32'd0);
    step();
    chk_all("reset_hold", 3'b000, 32'd0, 1'b0, 32'd0);

    reset = 1'b1;
    drive(2'b00, 1'b0, 32'd5, 32'd3, 32'd0, 32'd0);
    step();
    chk_all("first_add", 3'b010, 32'd8, 1'b0, 32'd0);

    // R-type decode sweep, A=12 B=10, pc=0x100
    drive(2'b10, 1'b0, 32'd12, 32'd10, 32'h20, 32'h100); step();
    chk_all("r_add", 3'b010, 32'd22, 1'b0, 32'h180);
    drive(2'b10, 1'b0, 32'd12, 32'd10, 32'h22, 32'h100); step();
    chk_all("r_sub", 3'b110, 32'd2, 1'b0, 32'h188);
    drive(2'b10, 1'b0, 32'd12, 32'd10, 32'h24, 32'h100); step();
    chk_all("r_and", 3'b000, 32'd8, 1'b0, 32'h190);
    drive(2'b10, 1'b0, 32'd12, 32'd10, 32'h25, 32'h100); step();
    chk_all("r_or", 3'b001, 32'd14, 1'b0, 32'h194);
    drive(2'b10, 1'b0, 32'd12, 32'd10, 32'h2A, 32'h100); step();
    chk_all("r_slt", 3'b111, 32'd0, 1'b1, 32'h1A8);
    drive(2'b10, 1'b0, 32'd12, 32'd10, 32'h27, 32'h100); step();
    chk_all("r_nor", 3'b100, 32'hFFFFFFF1, 1'b0, 32'h19C);
    drive(2'b10, 1'b0, 32'd12, 32'd10, 32'h3F, 32'h100); step();
    chk_all("r_unknown", 3'b010, 32'd22, 1'b0, 32'h1FC);

    // Branch compare
    drive(2'b01, 1'b0, 32'h1234, 32'h1234, 32'd0, 32'd4); step();
    chk_all("beq_equal", 3'b110, 32'd0, 1'b1, 32'd4);
    drive(2'b01, 1'b0, 32'd7, 32'd9, 32'd0, 32'd4); step();
    chk_all("beq_neq", 3'b110, 32'hFFFFFFFE, 1'b0, 32'd4);

    // Signed SLT and wrap
    drive(2'b10, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h2A, 32'd0); step();
    chk_all("slt_signed", 3'b111, 32'd1, 1'b0, 32'hA8);
    drive(2'b00, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0); step();
    chk_all("add_wrap", 3'b010, 32'h80000000, 1'b0, 32'd0);
    drive(2'b00, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0); step();
    chk_all("add_zero", 3'b010, 32'd0, 1'b1, 32'd0);

    // Immediate path, ori-style opcode and branch targets
    drive(2'b00, 1'b1, 32'd100, 32'd7, 32'hFFFFFFFC, 32'd44); step();
    chk_all("imm_neg", 3'b010, 32'd96, 1'b0, 32'd28);
    drive(2'b00, 1'b1, 32'd100, 32'd7, 32'd3, 32'd44); step();
    chk_all("imm_pos", 3'b010, 32'd103, 1'b0, 32'd56);
    drive(2'b11, 1'b1, 32'hF0, 32'd7, 32'h0F, 32'd0); step();
    chk_all("ori", 3'b001, 32'hFF, 1'b0, 32'h3C);

    // Back-to-back operations, one per cycle
    drive(2'b00, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0); step();
    chk_all("pipe0", 3'b010, 32'd3, 1'b0, 32'd0);
    drive(2'b01, 1'b0, 32'd10, 32'd3, 32'd0, 32'd0); step();
    chk_all("pipe1", 3'b110, 32'd7, 1'b0, 32'd0);
    drive(2'b10, 1'b0, 32'hFF00, 32'h0FF0, 32'h24, 32'd0); step();
    chk_all("pipe2", 3'b000, 32'h0F00, 1'b0, 32'h90);
    drive(2'b10, 1'b0, 32'd0, 32'd0, 32'h27, 32'd0); step();
    chk_all("pipe3", 3'b100, 32'hFFFFFFFF, 1'b0, 32'h9C);

    // Inputs changing between edges must not reach the outputs
    drive(2'b01, 1'b0, 32'd5, 32'd5, 32'd1, 32'd8);
    #3;
    chk_all("hold_between_edges", 3'b100, 32'hFFFFFFFF, 1'b0, 32'h9C);

    // Mid-run reset pulse between edges
    reset = 1'b0;
    #1;
    chk_all("midrun_reset", 3'b000, 32'd0, 1'b0, 32'd0);
    #1;
    reset = 1'b1;
    drive(2'b01, 1'b0, 32'd2, 32'd2, 32'd2, 32'd16); step();
    chk_all("post_reset_capture", 3'b110, 32'd0, 1'b1, 32'd24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
